mc_sample_ctrl: RTL and testbench

MC_SAMPLE_CTRL -- requirements
Module: mc_sample_ctrl

---
 rtl/mc_pkg.sv | 28 ++
 rtl/mc_lfsr10.sv | 21 ++
 rtl/mc_sample_ctrl.sv | 136 +++++++++++++
 tb/tb_mc_sample_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and constants for the Monte-Carlo sample controller
package mc_pkg;

  localparam int LFSR_W      = 10;
  localparam int COORD_LIMIT = 100;
  localparam int TAP_HI      = 9;
  localparam int TAP_LO      = 6;
  localparam int CMP_LAT     = 3;

  // Low 7 bits of an LFSR form the coordinate candidate
  localparam logic [LFSR_W-1:0] CAND_MASK = 10'h07F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_ARM,
    S_RUN1,
    S_RUN2,
    S_RUN3,
    S_CAPTURE,
    S_FIN
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
  endfunction

endpackage

// File: rtl/mc_lfsr10.sv
// rtl/mc_lfsr10.sv - 10-bit Fibonacci LFSR, taps (9,6), period 1023, steps when enabled
module mc_lfsr10
  import mc_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 10'h001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= SEED;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/mc_sample_ctrl.sv
// rtl/mc_sample_ctrl.sv - Monte-Carlo sample sequencer driving an external in-circle comparator
// Optional reject counter output enabled by MC_SAMPLE_REJECT_CNT_EN.
module mc_sample_ctrl
  import mc_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED_X = 10'h001,
  parameter logic [LFSR_W-1:0] SEED_Y = 10'h002
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       num_samples,
  input  logic              in_circle,
  output logic [LFSR_W-1:0] x_out,
  output logic [LFSR_W-1:0] y_out,
  output logic              cmp_reset,
  output logic              busy,
  output logic              done,
  output logic [15:0]       hits,
  output logic [15:0]       total
`ifdef MC_SAMPLE_REJECT_CNT_EN
  ,
  output logic [15:0]       rejects
`endif
);

  state_t            state;
  state_t            state_next;
  logic [LFSR_W-1:0] lfsr_x;
  logic [LFSR_W-1:0] lfsr_y;
  logic [LFSR_W-1:0] cand_x;
  logic [LFSR_W-1:0] cand_y;
  logic              cand_ok;
  logic              last_sample;
  logic              start_ok;
  logic [15:0]       n_lat;

  mc_lfsr10 #(.SEED(SEED_X)) u_lfsr_x (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (state == S_GEN),
    .q       (lfsr_x)
  );

  mc_lfsr10 #(.SEED(SEED_Y)) u_lfsr_y (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (state == S_GEN),
    .q       (lfsr_y)
  );

  assign cand_x      = lfsr_x & CAND_MASK;
  assign cand_y      = lfsr_y & CAND_MASK;
  assign cand_ok     = (cand_x < LFSR_W'(COORD_LIMIT)) && (cand_y < LFSR_W'(COORD_LIMIT));
  assign last_sample = (total + 16'd1) == n_lat;
  assign start_ok    = (state == S_IDLE) && start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmp_reset  = 1'b0;
    case (state)
      S_IDLE: begin
        cmp_reset = 1'b1;
        if (start) begin
          state_next = (num_samples == 16'd0) ? S_FIN : S_GEN;
        end
      end
      S_GEN:     if (cand_ok) state_next = S_ARM;
      S_ARM: begin
        cmp_reset  = 1'b1;
        state_next = S_RUN1;
      end
      S_RUN1:    state_next = S_RUN2;
      S_RUN2:    state_next = S_RUN3;
      S_RUN3:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = last_sample ? S_FIN : S_GEN;
      S_FIN: begin
        cmp_reset  = 1'b1;
        state_next = S_IDLE;
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // done is registered off FIN so it lands in the IDLE cycle, the same edge busy drops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_lat <= 16'd0;
      hits  <= 16'd0;
      total <= 16'd0;
      x_out <= '0;
      y_out <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= (state == S_FIN);
      if (start_ok) begin
        n_lat <= num_samples;
        hits  <= 16'd0;
        total <= 16'd0;
        busy  <= (num_samples != 16'd0);
      end else if (state == S_FIN) begin
        busy <= 1'b0;
      end
      if ((state == S_GEN) && cand_ok) begin
        x_out <= cand_x;
        y_out <= cand_y;
      end
      if (state == S_CAPTURE) begin
        hits  <= hits + {15'd0, in_circle};
        total <= total + 16'd1;
      end
    end
  end

`ifdef MC_SAMPLE_REJECT_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rejects <= 16'd0;
    end else if (start_ok) begin
      rejects <= 16'd0;
    end else if ((state == S_GEN) && !cand_ok && (rejects != 16'hFFFF)) begin
      rejects <= rejects + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_sample_ctrl.sv
// tb/tb_mc_sample_ctrl.sv - table-driven and randomized bench for mc_sample_ctrl with a comparator stage in the loop
module tb_mc_sample_ctrl;

  localparam logic [9:0] SX = 10'h001;
  localparam logic [9:0] SY = 10'h002;

  logic        clk = 1'b0;
  logic        reset_n, start, force_hit, cmp_q, in_circle;
  logic        start_r, in_circle_r;
  logic [15:0] num_samples, num_r, hits, total, hits_r, total_r;
  logic [9:0]  x_out, y_out, x_out_r, y_out_r;
  logic        cmp_reset, busy, done, cmp_reset_r, busy_r, done_r;
`ifdef MC_SAMPLE_REJECT_CNT_EN
  logic [15:0] rejects, rejects_r;
`endif

  int         vectors = 0;
  int         miscompares = 0;
  logic [9:0] mx, my;

  always #5 clk = ~clk;

  assign in_circle   = force_hit | cmp_q;
  assign in_circle_r = 1'b0;

  always_ff @(posedge clk) begin
    if (cmp_reset) cmp_q <= 1'b0;
    else cmp_q <= (int'(x_out) * int'(x_out) + int'(y_out) * int'(y_out)) < 10000;
  end

  mc_sample_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_samples(num_samples),
    .in_circle(in_circle), .x_out(x_out), .y_out(y_out), .cmp_reset(cmp_reset),
    .busy(busy), .done(done), .hits(hits), .total(total)
`ifdef MC_SAMPLE_REJECT_CNT_EN
    , .rejects(rejects)
`endif
  );

  mc_sample_ctrl #(.SEED_X(10'h07F), .SEED_Y(SY)) dut_r (
    .clk(clk), .reset_n(reset_n), .start(start_r), .num_samples(num_r),
    .in_circle(in_circle_r), .x_out(x_out_r), .y_out(y_out_r), .cmp_reset(cmp_reset_r),
    .busy(busy_r), .done(done_r), .hits(hits_r), .total(total_r)
`ifdef MC_SAMPLE_REJECT_CNT_EN
    , .rejects(rejects_r)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] lstep(input logic [9:0] q);
    return {q[8:0], q[9] ^ q[6]};
  endfunction

  // Reference: walk the LFSRs sample by sample, 1 cycle per GEN try, 5 more per sample, +2 for FIN/done
  task automatic model_run(input int n, input bit frc, input logic [9:0] ix, input logic [9:0] iy,
                           output logic [9:0] ox, output logic [9:0] oy,
                           output int h, output int cyc, output int rej, output int fx, output int fy);
    logic [9:0] lx, ly;
    int cx, cy;
    bit got;
    lx = ix; ly = iy; h = 0; cyc = 2; rej = 0; fx = -1; fy = -1; cx = 0; cy = 0;
    for (int s = 0; s < n; s++) begin
      got = 1'b0;
      while (!got) begin
        cx = int'(lx[6:0]);
        cy = int'(ly[6:0]);
        lx = lstep(lx);
        ly = lstep(ly);
        cyc++;
        if (cx < 100 && cy < 100) got = 1'b1;
        else rej++;
      end
      if (s == 0) begin fx = cx; fy = cy; end
      cyc += 5;
      if (frc || (cx * cx + cy * cy < 10000)) h++;
    end
    ox = lx; oy = ly;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_hits"}, int'(hits), 0);
    chk({tag, "_total"}, int'(total), 0);
    chk({tag, "_x"}, int'(x_out), 0);
    chk({tag, "_y"}, int'(y_out), 0);
    chk({tag, "_cmp_reset"}, int'(cmp_reset), 1);
`ifdef MC_SAMPLE_REJECT_CNT_EN
    chk({tag, "_rejects"}, int'(rejects), 0);
`endif
  endtask

  task automatic run(input int n, input bit frc, input int eh, input int et, input int efx,
                     input int efy, input int poke_at, input bit abort);
    logic [9:0] nx, ny;
    int h, cyc, rej, fx, fy, c, seen, win, armx, army, bad, fxa, fya, dn;
    bit prev_cr, busy_hi, got_done;
    model_run(n, frc, mx, my, nx, ny, h, cyc, rej, fx, fy);
    if (eh < 0) eh = h;
    if (efx < 0) efx = fx;
    if (efy < 0) efy = fy;
    force_hit = frc;
    @(negedge clk);
    start = 1'b1; num_samples = n[15:0];
    @(negedge clk);
    start = 1'b0;
    c = 1; seen = 0; win = 0; bad = 0; armx = 0; army = 0; fxa = -1; fya = -1;
    prev_cr = 1'b1; busy_hi = 1'b0; got_done = 1'b0;
    while (c < 20000) begin
      if (busy) busy_hi = 1'b1;
      if (win > 0 && !busy) win = 0;
      if (win > 0) begin
        if (cmp_reset !== 1'b0 || int'(x_out) != armx || int'(y_out) != army) bad++;
        if (win == 4) begin seen++; win = 0; end
        else win++;
      end else if (busy && cmp_reset && !prev_cr) begin
        armx = int'(x_out); army = int'(y_out); win = 1;
        if (seen == 0) begin fxa = armx; fya = army; end
      end
      prev_cr = cmp_reset;
      if (abort && seen == 1 && win == 2) begin
        reset_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        dn = 0;
        repeat (3) begin @(negedge clk); dn += int'(done); end
        chk("abort_no_done", dn, 0);
        reset_n = 1'b1;
        mx = SX; my = SY;
        return;
      end
      if (done) begin got_done = 1'b1; break; end
      if (c == poke_at) begin start = 1'b1; num_samples = 16'd9; end
      else begin start = 1'b0; num_samples = n[15:0]; end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("done_seen", int'(got_done), 1);
    chk("hits", int'(hits), eh);
    chk("total", int'(total), et);
    chk("cycles", c, cyc);
    chk("samples_seen", seen, n);
    chk("arm_window_errors", bad, 0);
    chk("busy_seen", int'(busy_hi), int'(n > 0));
    chk("busy_at_done", int'(busy), 0);
    if (n > 0) begin
      chk("first_x", fxa, efx);
      chk("first_y", fya, efy);
    end
`ifdef MC_SAMPLE_REJECT_CNT_EN
    chk("rejects", int'(rejects), rej);
`endif
    repeat (2) @(negedge clk);
    chk("total_hold", int'(total), et);
    chk("done_single", int'(done), 0);
    mx = nx; my = ny;
  endtask

  typedef struct {
    int n;
    bit frc;
    int eh;
    int et;
    int efx;
    int efy;
    int poke;
    bit abort;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int c, h, cyc, rej, fx, fy, n;
    logic [9:0] nx, ny;
    // n, force, hits, total, first x, first y, start-while-busy cycle, reset mid-run (-1: from model)
    tbl[0] = '{0,    1'b0, 0,  0,    -1, -1, 0, 1'b0};
    tbl[1] = '{4,    1'b1, 4,  4,     1,  2, 0, 1'b0};
    tbl[2] = '{1,    1'b1, 1,  1,    -1, -1, 0, 1'b0};
    tbl[3] = '{3,    1'b0, -1, 3,    -1, -1, 7, 1'b0};
    tbl[4] = '{5,    1'b0, -1, 5,    -1, -1, 0, 1'b1};
    tbl[5] = '{2,    1'b0, -1, 2,     1,  2, 0, 1'b0};
    tbl[6] = '{1000, 1'b0, -1, 1000, -1, -1, 0, 1'b0};

    reset_n = 1'b0; start = 1'b0; num_samples = 16'd0; force_hit = 1'b0;
    start_r = 1'b0; num_r = 16'd0;
    mx = SX; my = SY;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run(tbl[i].n, tbl[i].frc, tbl[i].eh, tbl[i].et, tbl[i].efx, tbl[i].efy, tbl[i].poke, tbl[i].abort);

    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(0, 25));
      run(n, 1'($urandom_range(0, 1)), -1, n, -1, -1, (n >= 2) ? int'($urandom_range(2, 8)) : 0, 1'b0);
    end

    @(negedge clk);
    start_r = 1'b1; num_r = 16'd2;
    @(negedge clk);
    start_r = 1'b0;
    c = 1;
    while (!done_r && c < 2000) begin @(negedge clk); c++; end
    model_run(2, 1'b0, 10'h07F, SY, nx, ny, h, cyc, rej, fx, fy);
    chk("rej_done", int'(done_r), 1);
    chk("rej_total", int'(total_r), 2);
    chk("rej_hits", int'(hits_r), 0);
    chk("rej_x_lt_100", int'(x_out_r < 10'd100), 1);
    chk("rej_cycles", c, cyc);
    chk("rej_first_gen_rejects", int'(cyc > 14), 1);
`ifdef MC_SAMPLE_REJECT_CNT_EN
    chk("rej_count", int'(rejects_r), rej);
    chk("rej_count_nonzero", int'(rejects_r >= 16'd1), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
